bus_burst_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one addr/data transfer bus among
//  NUM_REQ bus-functional masters. Grants one requester at a time for a

---
 rtl/bus_burst_arbiter.sv | 146 ++++++++++++++
 tb/tb_bus_burst_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_burst_arbiter.sv
// Round-robin burst arbiter: grants one master at a time for a clamped burst,
// counts beat acknowledges, and aborts a burst after TIMEOUT cycles without an ack.
//
// state | meaning
// IDLE  | bus free; the next winner is picked on this edge
// BURST | gnt held; counting beat_ack, watchdog running
module bus_burst_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 10,
  parameter int LEN_W     = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*LEN_W-1:0]         req_len,
  input  logic                             beat_ack,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [$clog2(NUM_REQ)-1:0]       gnt_id,
  output logic                             bus_busy,
  output logic [$clog2(MAX_BURST+1)-1:0]   beat_cnt,
  output logic                             burst_end,
  output logic                             abort
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int WD_W  = $clog2(TIMEOUT);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr, rr_nxt;
  logic [CNT_W-1:0]   len, len_nxt;
  logic [WD_W-1:0]    wdog, wdog_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [ID_W-1:0]    gnt_id_nxt;
  logic               busy_nxt, end_nxt, abort_nxt;
  logic [CNT_W-1:0]   cnt_nxt;

  logic               found;
  logic [ID_W-1:0]    win;
  logic [LEN_W-1:0]   len_raw;
  logic [CNT_W-1:0]   len_clamp;

  // Search starts one past the last winner so every master gets its turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    len_raw = req_len[int'(win)*LEN_W +: LEN_W];
    if (len_raw == '0)
      len_clamp = CNT_W'(1);
    else if (int'(len_raw) > MAX_BURST)
      len_clamp = CNT_W'(MAX_BURST);
    else
      len_clamp = CNT_W'(len_raw);
  end

  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr_ptr;
    len_nxt    = len;
    wdog_nxt   = wdog;
    gnt_nxt    = gnt;
    gnt_id_nxt = gnt_id;
    busy_nxt   = bus_busy;
    cnt_nxt    = beat_cnt;
    end_nxt    = 1'b0;
    abort_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt  = BURST;
          rr_nxt     = win;
          len_nxt    = len_clamp;
          wdog_nxt   = '0;
          gnt_nxt    = NUM_REQ'(1) << win;
          gnt_id_nxt = win;
          busy_nxt   = 1'b1;
          cnt_nxt    = '0;
        end
      end
      BURST: begin
        // An ack in the watchdog's last cycle still counts and suppresses abort.
        if (beat_ack) begin
          wdog_nxt = '0;
          if (beat_cnt == len - CNT_W'(1)) begin
            end_nxt   = 1'b1;
            gnt_nxt   = '0;
            busy_nxt  = 1'b0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end else if (wdog == WD_W'(TIMEOUT - 1)) begin
          abort_nxt = 1'b1;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
          wdog_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          wdog_nxt = wdog + WD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      len       <= '0;
      wdog      <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      bus_busy  <= 1'b0;
      beat_cnt  <= '0;
      burst_end <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      len       <= len_nxt;
      wdog      <= wdog_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      bus_busy  <= busy_nxt;
      beat_cnt  <= cnt_nxt;
      burst_end <= end_nxt;
      abort     <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_bus_burst_arbiter.sv
// Bench for bus_burst_arbiter: directed scenarios plus random traffic, all
// checked against a burst-level reference model (owner, beats left, quiet cycles).
module tb_bus_burst_arbiter;

  localparam int N       = 4;
  localparam int MAXB    = 10;
  localparam int LW      = 4;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*LW-1:0] req_len;
  logic          beat_ack;
  logic [N-1:0]  gnt;
  logic [1:0]    gnt_id;
  logic          bus_busy;
  logic [3:0]    beat_cnt;
  logic          burst_end;
  logic          abort;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit m_busy;
  int m_owner, m_last, m_len, m_left, m_quiet;
  bit e_end, e_abort;

  bus_burst_arbiter #(.NUM_REQ(N), .MAX_BURST(MAXB), .LEN_W(LW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .beat_ack(beat_ack),
    .gnt(gnt), .gnt_id(gnt_id), .bus_busy(bus_busy), .beat_cnt(beat_cnt),
    .burst_end(burst_end), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_last  = N - 1;
    m_owner = 0;
    m_len   = 0;
    m_left  = 0;
    m_quiet = 0;
    e_end   = 1'b0;
    e_abort = 1'b0;
  endtask

  task automatic model_update(input logic [N-1:0] r, input logic [N*LW-1:0] l, input logic a);
    int w, lv;
    e_end   = 1'b0;
    e_abort = 1'b0;
    if (!m_busy) begin
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && r[(m_last + k) % N]) w = (m_last + k) % N;
      if (w >= 0) begin
        lv = (l >> (w * LW)) & ((1 << LW) - 1);
        if (lv == 0) lv = 1;
        if (lv > MAXB) lv = MAXB;
        m_owner = w;
        m_last  = w;
        m_len   = lv;
        m_left  = lv;
        m_quiet = 0;
        m_busy  = 1'b1;
      end
    end else if (a) begin
      m_left--;
      m_quiet = 0;
      if (m_left == 0) begin
        m_busy = 1'b0;
        e_end  = 1'b1;
      end
    end else begin
      m_quiet++;
      if (m_quiet == TIMEOUT) begin
        m_busy  = 1'b0;
        e_abort = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("gnt", 32'(gnt), m_busy ? (32'd1 << m_owner) : 32'd0);
    check("bus_busy", 32'(bus_busy), 32'(m_busy));
    check("beat_cnt", 32'(beat_cnt), m_busy ? 32'(m_len - m_left) : 32'd0);
    check("burst_end", 32'(burst_end), 32'(e_end));
    check("abort", 32'(abort), 32'(e_abort));
    if (m_busy) check("gnt_id", 32'(gnt_id), 32'(m_owner));
  endtask

  // Apply inputs just after a falling edge, let one rising edge pass, check.
  task automatic step(input logic [N-1:0] r, input logic [N*LW-1:0] l, input logic a);
    req      = r;
    req_len  = l;
    beat_ack = a;
    model_update(r, l, a);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    req_len  = '0;
    beat_ack = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    int ng, n, p;
    logic [N-1:0] r;

    do_reset();

    // single requester, len 3
    step(4'b0100, 16'h0300, 1'b0);
    check("t1_gnt", 32'(gnt), 32'b0100);
    step(4'b0000, 16'h0300, 1'b1);
    step(4'b0000, 16'h0300, 1'b1);
    step(4'b0000, 16'h0300, 1'b1);
    check("t1_end", 32'(burst_end), 32'd1);
    check("t1_gnt_off", 32'(gnt), 32'd0);

    // rotation with all requesting, len 1
    do_reset();
    ng = 0;
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, 16'h1111, 1'b1);
      if (gnt != '0 && ng < 5) begin
        check("t2_order", 32'(gnt_id), 32'(order[ng]));
        ng++;
      end
    end
    check("t2_grants", 32'(ng), 32'd5);

    // length clamping: 0 -> 1 beat, 15 -> 10 beats
    do_reset();
    step(4'b0001, 16'h0000, 1'b0);
    step(4'b0000, 16'h0000, 1'b1);
    check("t3_len0_end", 32'(burst_end), 32'd1);
    step(4'b0001, 16'h000f, 1'b0);
    n = 0;
    for (int i = 0; i < 30 && burst_end !== 1'b1; i++) begin
      step(4'b0000, 16'h000f, 1'b1);
      n++;
    end
    check("t3_len15_acks", 32'(n), 32'd10);

    // watchdog abort, then round robin moves past the aborted master
    do_reset();
    step(4'b0110, 16'h0040, 1'b0);
    check("t4_gnt1", 32'(gnt_id), 32'd1);
    step(4'b0110, 16'h0040, 1'b1);
    step(4'b0110, 16'h0040, 1'b1);
    n = 0;
    for (int i = 0; i < 30 && abort !== 1'b1; i++) begin
      step(4'b0110, 16'h0040, 1'b0);
      n++;
    end
    check("t4_abort_lat", 32'(n), 32'd16);
    check("t4_gnt_off", 32'(gnt), 32'd0);
    step(4'b0110, 16'h0040, 1'b0);
    check("t4_next_id", 32'(gnt_id), 32'd2);

    // asynchronous reset in the middle of a burst
    do_reset();
    step(4'b0100, 16'h0600, 1'b0);
    step(4'b0100, 16'h0600, 1'b1);
    step(4'b0100, 16'h0600, 1'b1);
    check("t5_cnt2", 32'(beat_cnt), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t5_gnt", 32'(gnt), 32'd0);
    check("t5_busy", 32'(bus_busy), 32'd0);
    check("t5_cnt", 32'(beat_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1010, 16'h1111, 1'b0);
    check("t5_first", 32'(gnt_id), 32'd1);

    // requester drops after grant; acks in idle are ignored
    do_reset();
    step(4'b0001, 16'h0005, 1'b0);
    n = 0;
    for (int i = 0; i < 20 && burst_end !== 1'b1; i++) begin
      step(4'b0000, 16'h0005, 1'b1);
      n++;
    end
    check("t6_beats", 32'(n), 32'd5);
    for (int i = 0; i < 3; i++) step(4'b0000, 16'h0005, 1'b1);
    check("t6_idle_cnt", 32'(beat_cnt), 32'd0);

    // random traffic in phases of different ack density
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      case ((i / 250) % 3)
        0: p = 90;
        1: p = 55;
        default: p = 4;
      endcase
      r = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom());
      step(r, 16'($urandom()), 1'($urandom_range(0, 99) < p));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
